// File: rtl/alu_sequencer_if.sv
// Command/response handshake plus the shared ALU drive/readback bus of the sequencer.
// The slave modport is the sequencer's view; master is the command source/ALU side.
interface alu_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic [WIDTH-1:0] alu_data;
  logic             alu_in1;
  logic             alu_in2;
  logic             alu_out_en;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_result;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready, alu_result,
    output cmd_ready, res_valid, res_data, res_err,
           alu_data, alu_in1, alu_in2, alu_out_en, alu_control
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready, alu_result,
    input  cmd_ready, res_valid, res_data, res_err,
           alu_data, alu_in1, alu_in2, alu_out_en, alu_control
  );
endinterface

// File: rtl/alu_sequencer.sv
// Command front-end for the 16-bit ALU: loads operands over the shared data bus,
// holds the opcode while the ALU settles, reads the result back and returns it.
module alu_sequencer #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  alu_sequencer_if.slave     bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD_A, HOLD_A, LOAD_B, HOLD_B, EXEC, READ, RESP
  } state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] settle_cnt;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b1111, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b0101, 4'b0110, 4'b0111, 4'b1101: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // All bus outputs are registered and set on the transition into the state that owns them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      op_q            <= '0;
      b_q             <= '0;
      settle_cnt      <= '0;
      bus.cmd_ready   <= 1'b1;
      bus.alu_data    <= '0;
      bus.alu_in1     <= 1'b0;
      bus.alu_in2     <= 1'b0;
      bus.alu_out_en  <= 1'b0;
      bus.alu_control <= 4'b0000;
      bus.res_valid   <= 1'b0;
      bus.res_data    <= '0;
      bus.res_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q          <= bus.cmd_op;
            b_q           <= bus.cmd_b;
            bus.cmd_ready <= 1'b0;
            if (op_legal(bus.cmd_op)) begin
              state        <= LOAD_A;
              bus.alu_data <= bus.cmd_a;
              bus.alu_in1  <= 1'b1;
            end else begin
              state         <= RESP;
              bus.res_valid <= 1'b1;
              bus.res_err   <= 1'b1;
              bus.res_data  <= '0;
            end
          end
        end
        LOAD_A: begin
          state       <= HOLD_A;
          bus.alu_in1 <= 1'b0;
        end
        HOLD_A: begin
          state        <= LOAD_B;
          bus.alu_data <= b_q;
          bus.alu_in2  <= 1'b1;
        end
        LOAD_B: begin
          state       <= HOLD_B;
          bus.alu_in2 <= 1'b0;
        end
        HOLD_B: begin
          state           <= EXEC;
          bus.alu_data    <= '0;
          bus.alu_control <= op_q;
          settle_cnt      <= CNT_W'(SETTLE_CYCLES - 1);
        end
        EXEC: begin
          if (settle_cnt == '0) begin
            state          <= READ;
            bus.alu_out_en <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        READ: begin
          state           <= RESP;
          bus.alu_out_en  <= 1'b0;
          bus.alu_control <= 4'b0000;
          bus.res_data    <= bus.alu_result;
          bus.res_err     <= 1'b0;
          bus.res_valid   <= 1'b1;
        end
        RESP: begin
          if (bus.res_ready) begin
            state         <= IDLE;
            bus.res_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a behavioural ALU answers the bus, stimulus
// pushes hand-computed responses and a monitor pops and compares them.
module tb_alu_sequencer;

  localparam int WIDTH  = 16;
  localparam int SETTLE = 2;
  localparam int LAT    = 6 + SETTLE;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic illegal_win = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_sequencer #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural ALU: two operand registers, combinational result gated by outSignal.
  logic [WIDTH-1:0] r1 = '0, r2 = '0, alu_f;
  always @(posedge clk) begin
    if (bus.alu_in1) r1 <= bus.alu_data;
    if (bus.alu_in2) r2 <= bus.alu_data;
  end
  always_comb begin
    alu_f = '0;
    case (bus.alu_control)
      4'b1111: alu_f = r1 + r2;
      4'b0001: alu_f = r1 - r2;
      4'b0010: alu_f = ~r1;
      4'b0011: alu_f = r1 & r2;
      4'b0100: alu_f = r1 | r2;
      4'b0101: alu_f = r1 ^ r2;
      4'b0110: alu_f = r1 << 1;
      4'b0111: alu_f = r1 >> 1;
      4'b1101: alu_f = r2;
      default: alu_f = '0;
    endcase
  end
  assign bus.alu_result = bus.alu_out_en ? alu_f : '0;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             err;
    int               hs_cyc;
    int               lat;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops on each new response, checks stability while stalled and bus invariants.
  logic             prev_v = 1'b0;
  logic [WIDTH-1:0] held_d = '0;
  logic             held_e = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      if (bus.res_valid && !prev_v) begin
        check("response_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("res_data", 32'(bus.res_data), 32'(e.data));
          check("res_err", 32'(bus.res_err), 32'(e.err));
          check("latency", 32'(cyc - e.hs_cyc), 32'(e.lat));
        end
        held_d = bus.res_data;
        held_e = bus.res_err;
      end else if (bus.res_valid && prev_v) begin
        check("res_data_stable", 32'(bus.res_data), 32'(held_d));
        check("res_err_stable", 32'(bus.res_err), 32'(held_e));
      end
      check("strobes_onehot", 32'(32'(bus.alu_in1) + 32'(bus.alu_in2) + 32'(bus.alu_out_en) <= 1), 32'd1);
      if (bus.cmd_ready || bus.res_valid)
        check("control_idle_zero", 32'(bus.alu_control), 32'd0);
      if (bus.cmd_ready || bus.res_valid || bus.alu_out_en)
        check("data_idle_zero", 32'(bus.alu_data), 32'd0);
      if (illegal_win)
        check("illegal_no_strobe", {29'd0, bus.alu_in1, bus.alu_in2, bus.alu_out_en}, 32'd0);
    end
    prev_v = bus.res_valid;
  end

  task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] ed, input logic ee, input int lat, input bit expect_res);
    int n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    if (expect_res) sb.push_back('{data: ed, err: ee, hs_cyc: cyc, lat: lat});
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !bus.cmd_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size() == 0 && bus.cmd_ready), 32'd1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_strobes", {29'd0, bus.alu_in1, bus.alu_in2, bus.alu_out_en}, 32'd0);
    check("rst_control", 32'(bus.alu_control), 32'd0);
    check("rst_data", 32'(bus.alu_data), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    send(4'b1111, 16'h1234, 16'h0001, 16'h1235, 1'b0, LAT, 1'b1);
    send(4'b0001, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, LAT, 1'b1);
    send(4'b0010, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, LAT, 1'b1);
    send(4'b0011, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, LAT, 1'b1);
    send(4'b0011, 16'h0F0F, 16'hFFFF, 16'h0F0F, 1'b0, LAT, 1'b1);
    wait_idle();

    illegal_win = 1'b1;
    send(4'b0000, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1, 1'b1);
    send(4'b1000, 16'h3333, 16'h4444, 16'h0000, 1'b1, 1, 1'b1);
    wait_idle();
    illegal_win = 1'b0;

    // Stalled consumer: response must hold and a pending command must wait.
    bus.res_ready = 1'b0;
    send(4'b0101, 16'h00F0, 16'h0FF0, 16'h0F00, 1'b0, LAT, 1'b1);
    begin
      int n = 0;
      while (!bus.res_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("stall_res_valid_seen", 32'(bus.res_valid), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'b0001;
    bus.cmd_a     = 16'h0005;
    bus.cmd_b     = 16'h0003;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("stall_res_valid", 32'(bus.res_valid), 32'd1);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    wait_idle();

    // Abort during EXEC with an asynchronous reset pulse.
    send(4'b0101, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, LAT, 1'b0);
    begin
      int n = 0;
      while (bus.alu_control == 4'b0000 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("reached_exec", 32'(bus.alu_control), 32'(4'b0101));
    #1 reset = 1'b0;
    #1;
    check("abort_strobes", {29'd0, bus.alu_in1, bus.alu_in2, bus.alu_out_en}, 32'd0);
    check("abort_control", 32'(bus.alu_control), 32'd0);
    check("abort_res_valid", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("post_abort_ready", 32'(bus.cmd_ready), 32'd1);
    check("post_abort_no_res", 32'(bus.res_valid), 32'd0);
    send(4'b0100, 16'h00F0, 16'h000F, 16'h00FF, 1'b0, LAT, 1'b1);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
